uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_transmitter` among several byte sources. Each requester presents a byte with a level request. The arbiter picks one, latches its byte, pulses `tx_start` and holds the byte stable until the transmitter reports frame completion. It sits between the request sources (debounced buttons, status reporters, loopback echo) and the transmitter input, alongside `baud_rate_generator`.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `DATA_W`, default 8: byte width.
- `TIMEOUT_CYC`, default 200000: maximum number of `system_clk` cycles spent waiting for `tx_done` (one 9600-baud frame is about 104200 cycles at 100 MHz).
- `system_clk` in, 1 bit: system clock, 100 MHz.
- `rst` in, 1 bit: synchronous reset, active-high.
- `req` in, `NUM_REQ` bits: request level, one bit per requester.
- `req_data` in, `NUM_REQ*DATA_W` bits: requester i's byte is in bits [i*DATA_W +: DATA_W].
- `ack` out, `NUM_REQ` bits: one-cycle pulse when that requester's byte is latched.
- `tx_start` out, 1 bit: one-cycle start pulse to the transmitter.
- `tx_byte` out, `DATA_W` bits: byte to the transmitter; stable from the start pulse until the frame ends.
- `tx_done` in, 1 bit: one-cycle pulse from the transmitter at the end of the stop bit.
- `grant_id` out, `$clog2(NUM_REQ)` bits: index of the current or last granted requester.
- `busy` out, 1 bit: high in every state except IDLE.
- `timeout_err` out, 1 bit: one-cycle pulse on watchdog expiry.

## Operation
- FSM states and transitions:
  - IDLE → LAUNCH when any `req` bit is high.
  - LAUNCH → WAIT_DONE unconditionally, after one cycle.
  - WAIT_DONE → IDLE on `tx_done` or on timeout.
- Round-robin arbitration is evaluated in IDLE:
  - The search starts at `last_grant+1` and wraps modulo `NUM_REQ`.
  - The first requester with `req` high wins.
  - `last_grant` resets to `NUM_REQ-1`, so requester 0 has first priority after reset.
- On IDLE→LAUNCH, the winner's byte is registered into `tx_byte`, and its index into `grant_id` and `last_grant`.
- In LAUNCH:
  - `tx_start`=1 and `ack[grant_id]`=1 for exactly one cycle.
  - All other `ack` bits are 0.
- Requester handshake:
  - Hold `req` and data stable until `ack`.
  - The cycle after `ack`, deassert `req` or present the next byte with `req` still high.
  - A `req` that drops before being granted is simply not served; no error is raised.
- In WAIT_DONE:
  - A counter `wd_cnt`, `$clog2(TIMEOUT_CYC+1)` bits, increments from 0 each cycle.
  - When `wd_cnt == TIMEOUT_CYC-1` and `tx_done` is low, `timeout_err` pulses and the FSM returns to IDLE.
  - `wd_cnt` clears on entry to WAIT_DONE.
- Boundary cases:
  - `tx_done` and timeout in the same cycle: `tx_done` wins and `timeout_err` stays 0.
  - `tx_done` arriving in IDLE or LAUNCH is ignored.
  - `req` changes during LAUNCH or WAIT_DONE have no effect until the next IDLE.
- Reset values (synchronous `rst`, including mid-frame):
  - State IDLE.
  - `tx_start`, `ack`, `busy`, `timeout_err`, `tx_byte`, `grant_id` all 0.
  - `wd_cnt`=0; `last_grant`=`NUM_REQ-1`.
  - No `tx_start` is issued for an aborted grant.

## Timing
- If `req` is seen high in IDLE at edge N, then `tx_start`, `ack` and `busy` are high during cycle N+1.
- `tx_byte` is valid from cycle N+1 and held until the FSM returns to IDLE.
- `tx_done` at edge M puts the FSM in IDLE during M+1. The earliest next `tx_start` is cycle M+2, giving a minimum gap of one IDLE cycle between frames.
- Back-to-back throughput: one byte per frame time plus 2 cycles.
- All outputs are registered, with no combinational paths from input to output.

## Configuration
- `UART_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins. `last_grant` still records the winner, but the search always starts at 0.
- `UART_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described above.
- Neither the interface nor the timing changes between the two modes.

## Test plan
- **Single request:** after reset, `req`=4'b0100 with byte 0x5A.
  - `tx_start` and `ack`=4'b0100 in the cycle after the request.
  - `tx_byte`=0x5A and `grant_id`=2.
  - The byte is held until the `tx_done` pulse, then `busy` falls one cycle later.
- **Round-robin fairness:** all four `req` held high continuously, with each requester presenting a new byte after its `ack`.
  - Grants go 0,1,2,3,0 in order.
  - With `UART_ARB_FIXED_PRIO_EN` defined, grants are 0,0,0.
- **Watchdog:** `TIMEOUT_CYC`=16 and `tx_done` never asserted.
  - `timeout_err` pulses exactly 16 cycles after entering WAIT_DONE, and the FSM returns to IDLE.
  - A repeat run with `tx_done` and expiry in the same cycle gives `timeout_err`=0.
- **Reset mid-frame:** `rst` asserted during WAIT_DONE.
  - The next cycle shows all outputs at 0.
  - With `req`=4'b1111 after reset, the first grant is requester 0.
- **Withdrawn request:** `req[1]` pulses high for one cycle while the arbiter is in WAIT_DONE serving requester 3.
  - No `ack[1]` is issued and the next grant goes to the next active requester.
  - A stray `tx_done` in IDLE produces no state change.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                        system_clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        tx_start,
    output logic [DATA_W-1:0]           tx_byte,
    input  logic                        tx_done,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        timeout_err
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     last_grant;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     cand_id;
    logic                win_vld;
    int                  cand;
    logic [WD_W-1:0]     wd_cnt;
    logic                wd_expire;
    logic                launch;
    logic [NUM_REQ-1:0]  ack_d;
    logic                busy_d;
    logic                timeout_d;

    assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    // First requesting index found when scanning from the search origin.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        cand    = 0;
        cand_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
            cand = k;
`else
            cand = (int'(last_grant) + 1 + k) % NUM_REQ;
`endif
            cand_id = ID_W'(cand);
            if (!win_vld && req[cand_id]) begin
                win_vld = 1'b1;
                win_id  = cand_id;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (win_vld) state_nxt = LAUNCH;
            LAUNCH:    state_nxt = WAIT_DONE;
            WAIT_DONE: if (tx_done || wd_expire) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; tx_done beats a coincident expiry.
    always_comb begin
        launch    = (state == IDLE) && win_vld;
        ack_d     = '0;
        if (launch) ack_d[win_id] = 1'b1;
        busy_d    = (state_nxt != IDLE);
        timeout_d = (state == WAIT_DONE) && wd_expire && !tx_done;
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            state       <= IDLE;
            tx_start    <= 1'b0;
            ack         <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            tx_byte     <= '0;
            grant_id    <= '0;
            last_grant  <= ID_W'(NUM_REQ - 1);
            wd_cnt      <= '0;
        end else begin
            state       <= state_nxt;
            tx_start    <= launch;
            ack         <= ack_d;
            busy        <= busy_d;
            timeout_err <= timeout_d;
            if (launch) begin
                tx_byte    <= req_data[int'(win_id)*DATA_W +: DATA_W];
                grant_id   <= win_id;
                last_grant <= win_id;
            end
            if (state == WAIT_DONE) wd_cnt <= wd_cnt + 1'b1;
            else                    wd_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter in its default round-robin build, TIMEOUT_CYC=16.
module tb_uart_tx_arbiter;
    logic        system_clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] exp_b [4];
    int exp_g [5] = '{0, 1, 2, 3, 0};

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
        .system_clk (system_clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .tx_start   (tx_start),
        .tx_byte    (tx_byte),
        .tx_done    (tx_done),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 system_clk = ~system_clk;

    task automatic tick();
        @(posedge system_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        req_data[i*8 +: 8] = b;
        exp_b[i] = b;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_tx_start"}, 32'(tx_start), 0);
        check({tag, "_ack"}, 32'(ack), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_timeout"}, 32'(timeout_err), 0);
        check({tag, "_tx_byte"}, 32'(tx_byte), 0);
        check({tag, "_grant_id"}, 32'(grant_id), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; req_data = '0; tx_done = 1'b0;
        for (int i = 0; i < 4; i++) exp_b[i] = 8'h00;
        do_reset();
        check_zero_outputs("reset");

        // Single request from requester 2
        set_byte(2, 8'h5A);
        req = 4'b0100;
        tick();
        check("single_tx_start", 32'(tx_start), 1);
        check("single_ack", 32'(ack), 'h4);
        check("single_busy", 32'(busy), 1);
        check("single_tx_byte", 32'(tx_byte), 'h5A);
        check("single_grant_id", 32'(grant_id), 2);
        req = 4'b0000;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("launch_done_ignored_busy", 32'(busy), 1);
        check("wait_tx_start_low", 32'(tx_start), 0);
        check("wait_ack_low", 32'(ack), 0);
        tick(); tick();
        check("single_byte_held", 32'(tx_byte), 'h5A);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("single_busy_fell", 32'(busy), 0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("stray_done_busy", 32'(busy), 0);
        check("stray_done_tx_start", 32'(tx_start), 0);
        check("stray_done_timeout", 32'(timeout_err), 0);

        // Round-robin fairness with all requesters always active
        do_reset();
        for (int i = 0; i < 4; i++) set_byte(i, 8'(8'h10 + i));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 10 && !tx_start; c++) tick();
            check($sformatf("rr%0d_tx_start", k), 32'(tx_start), 1);
            check($sformatf("rr%0d_grant", k), 32'(grant_id), 32'(exp_g[k]));
            check($sformatf("rr%0d_ack", k), 32'(ack), 32'(1) << exp_g[k]);
            check($sformatf("rr%0d_byte", k), 32'(tx_byte), 32'(exp_b[exp_g[k]]));
            set_byte(exp_g[k], 8'(8'h20 + k));
            tick(); tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            check($sformatf("rr%0d_idle_gap", k), 32'(busy), 0);
        end
        req = 4'b0000;
        tick();

        // Watchdog expiry
        set_byte(0, 8'h77);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        for (int c = 0; c < 15; c++) tick();
        check("wd_no_early_timeout", 32'(timeout_err), 0);
        check("wd_still_busy", 32'(busy), 1);
        tick();
        check("wd_timeout_pulse", 32'(timeout_err), 1);
        check("wd_back_idle", 32'(busy), 0);
        tick();
        check("wd_timeout_one_cycle", 32'(timeout_err), 0);

        // Watchdog expiry coinciding with tx_done
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        for (int c = 0; c < 15; c++) tick();
        check("wd2_still_busy", 32'(busy), 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("wd2_done_wins", 32'(timeout_err), 0);
        check("wd2_back_idle", 32'(busy), 0);

        // Reset mid-frame while serving requester 1
        set_byte(1, 8'h3C);
        req = 4'b0010;
        tick();
        check("mid_grant1", 32'(grant_id), 1);
        req = 4'b0000;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero_outputs("midrst");
        req = 4'b1111;
        tick();
        check("midrst_first_start", 32'(tx_start), 1);
        check("midrst_first_grant", 32'(grant_id), 0);
        check("midrst_first_ack", 32'(ack), 'h1);
        req = 4'b0000;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;

        // Withdrawn request from requester 1 while serving requester 3
        set_byte(3, 8'hE1);
        set_byte(2, 8'h9B);
        req = 4'b1000;
        tick();
        check("wd_serve3_grant", 32'(grant_id), 3);
        req = 4'b0100;
        tick();
        req = 4'b0110;
        tick();
        req = 4'b0100;
        check("withdraw_no_ack", 32'(ack), 0);
        check("withdraw_no_start", 32'(tx_start), 0);
        tick();
        check("withdraw_no_ack2", 32'(ack), 0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        check("withdraw_next_start", 32'(tx_start), 1);
        check("withdraw_next_grant", 32'(grant_id), 2);
        check("withdraw_next_ack", 32'(ack), 'h4);
        check("withdraw_next_byte", 32'(tx_byte), 'h9B);
        req = 4'b0000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
